fft_bf_sched: RTL and testbench

FFT_BF_SCHED -- requirements
Module: fft_bf_sched

---
 rtl/fft_bf_sched_pkg.sv | 17 +
 rtl/fft_addr_pipe.sv | 53 +++++
 rtl/fft_bf_sched.sv | 184 ++++++++++++++++++
 tb/tb_fft_bf_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_bf_sched_pkg.sv
// Shared definitions for the FFT butterfly scheduler.
//   fft_sched_state_t : scheduler FSM states
//   FFT_N_DEFAULT     : default transform size (points)
//   BF_LAT_DEFAULT    : default butterfly input-to-output latency (cycles)
package fft_bf_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fft_sched_state_t;

  localparam int unsigned FFT_N_DEFAULT  = 8;
  localparam int unsigned BF_LAT_DEFAULT = 1;

endpackage

// File: rtl/fft_addr_pipe.sv
// Delay line for butterfly address/twiddle bundles, DEPTH stages deep.
// Every stage carries {valid, addr_a, addr_b, tw}.
//   clk, reset          : clock, asynchronous active-high reset (clears all stages)
//   in_valid/in_addr_*/in_tw : bundle entering stage 1
//   s1_valid, s1_tw     : stage 1 output (one cycle after input)
//   last_valid/last_addr_* : stage DEPTH output (DEPTH cycles after input)
module fft_addr_pipe #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 3,
  parameter int unsigned TW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr_a,
  input  logic [AW-1:0] in_addr_b,
  input  logic [TW-1:0] in_tw,
  output logic          s1_valid,
  output logic [TW-1:0] s1_tw,
  output logic          last_valid,
  output logic [AW-1:0] last_addr_a,
  output logic [AW-1:0] last_addr_b
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;
    logic [TW-1:0] tw;
  } pipe_entry_t;

  pipe_entry_t stage_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= '{valid: in_valid, addr_a: in_addr_a, addr_b: in_addr_b, tw: in_tw};
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign s1_valid    = stage_q[0].valid;
  assign s1_tw       = stage_q[0].tw;
  assign last_valid  = stage_q[DEPTH-1].valid;
  assign last_addr_a = stage_q[DEPTH-1].addr_a;
  assign last_addr_b = stage_q[DEPTH-1].addr_b;

endmodule

// File: rtl/fft_bf_sched.sv
// Radix-2 DIT butterfly scheduler over an in-place, bit-reversed sample memory.
// Issues one butterfly per cycle for LOG2N stages of FFT_N/2 butterflies, then
// drains the 1+BF_LAT pipeline before the next stage so reads never overtake
// the previous stage's writes.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   start                 : single-cycle run request (ignored unless idle)
//   busy, done            : run in progress / one-cycle end-of-run pulse
//   rd_en, rd_addr_a/b    : sample-memory read strobe and addresses
//   bf_enable, tw_idx     : butterfly input valid and twiddle index (rd + 1)
//   wr_en, wr_addr_a/b    : write strobe and addresses (rd + 1 + BF_LAT)
//   cycle_count           : busy-cycle counter, saturating, present only when
//                           FFT_BF_SCHED_CYCLE_CNT_EN is defined
module fft_bf_sched
  import fft_bf_sched_pkg::*;
#(
  parameter int unsigned FFT_N  = FFT_N_DEFAULT,
  parameter int unsigned BF_LAT = BF_LAT_DEFAULT,
  localparam int unsigned LOG2N = $clog2(FFT_N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_addr_a,
  output logic [LOG2N-1:0] rd_addr_b,
  output logic             bf_enable,
  output logic [LOG2N-2:0] tw_idx,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_addr_a,
  output logic [LOG2N-1:0] wr_addr_b
`ifdef FFT_BF_SCHED_CYCLE_CNT_EN
  ,
  output logic [15:0]      cycle_count
`endif
);

  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned DW = $clog2(BF_LAT + 1);

  fft_sched_state_t state, state_next;

  logic [LOG2N-1:0] stage_q;
  logic [KW-1:0]    bfly_q;
  logic [DW-1:0]    drain_q;

  logic last_bfly;
  logic last_stage;
  logic drain_end;

  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] pos;
  logic [LOG2N-1:0] grp;
  logic [LOG2N-1:0] addr_a;
  logic [LOG2N-1:0] addr_b;
  logic [KW-1:0]    tw;
  logic [31:0]      stage_w;

  assign last_bfly  = (bfly_q == KW'(FFT_N / 2 - 1));
  assign last_stage = (stage_q == LOG2N'(LOG2N - 1));
  assign drain_end  = (drain_q == DW'(BF_LAT));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (start) state_next = ISSUE;
      ISSUE: if (last_bfly) state_next = DRAIN;
      DRAIN: if (drain_end) state_next = last_stage ? DONE : ISSUE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage, butterfly and drain counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q <= '0;
      bfly_q  <= '0;
      drain_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            stage_q <= '0;
            bfly_q  <= '0;
            drain_q <= '0;
          end
        end
        ISSUE: begin
          bfly_q  <= last_bfly ? '0 : bfly_q + 1'b1;
          drain_q <= '0;
        end
        DRAIN: begin
          if (drain_end) begin
            drain_q <= '0;
            if (!last_stage) stage_q <= stage_q + 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        DONE: begin
          stage_q <= '0;
          bfly_q  <= '0;
          drain_q <= '0;
        end
        default: begin
          stage_q <= '0;
          bfly_q  <= '0;
          drain_q <= '0;
        end
      endcase
    end
  end

  // Butterfly addressing: span = 2^s, pos = k mod span, grp = k / span.
  // Division and modulo by a power of two reduce to shift and mask.
  always_comb begin
    stage_w = 32'(stage_q);
    span    = LOG2N'(1) << stage_w;
    pos     = LOG2N'(bfly_q) & (span - 1'b1);
    grp     = LOG2N'(bfly_q) >> stage_w;
    addr_a  = (grp << (stage_w + 1)) | pos;
    addr_b  = addr_a | span;
    tw      = KW'(pos << (LOG2N - 1 - stage_w));
  end

  // Output logic
  always_comb begin
    busy      = (state != IDLE);
    done      = (state == DONE);
    rd_en     = (state == ISSUE);
    rd_addr_a = '0;
    rd_addr_b = '0;
    if (state == ISSUE) begin
      rd_addr_a = addr_a;
      rd_addr_b = addr_b;
    end
  end

  // Twiddle index rides the pipeline with the addresses so it emerges
  // aligned with bf_enable, one cycle after the read (read latency 1).
  fft_addr_pipe #(
    .DEPTH (1 + BF_LAT),
    .AW    (LOG2N),
    .TW    (KW)
  ) u_addr_pipe (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (rd_en),
    .in_addr_a   (rd_addr_a),
    .in_addr_b   (rd_addr_b),
    .in_tw       (rd_en ? tw : '0),
    .s1_valid    (bf_enable),
    .s1_tw       (tw_idx),
    .last_valid  (wr_en),
    .last_addr_a (wr_addr_a),
    .last_addr_b (wr_addr_b)
  );

`ifdef FFT_BF_SCHED_CYCLE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (state == IDLE && start) begin
      cycle_count <= '0;
    end else if (state != IDLE && cycle_count != 16'hFFFF) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft_bf_sched.sv
module tb_fft_bf_sched;

  localparam int N     = 8;
  localparam int LOG2N = 3;
  localparam int TRMAX = 2048;
  localparam int WIN   = 31;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       bf;
    logic [1:0] tw;
    logic       wr;
    logic [2:0] wa;
    logic [2:0] wb;
  } snap_t;

  typedef struct {
    int         st;
    int         j;
    logic [2:0] a;
    logic [2:0] b;
    logic [1:0] tw;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic start;

  logic       busy1, done1, rd_en1, bf1, wr1;
  logic [2:0] ra1, rb1, wa1, wb1;
  logic [1:0] tw1;
  logic       busy3, done3, rd_en3, bf3, wr3;
  logic [2:0] ra3, rb3, wa3, wb3;
  logic [1:0] tw3;
`ifdef FFT_BF_SCHED_CYCLE_CNT_EN
  logic [15:0] cc1, cc3;
`endif

  fft_bf_sched #(.FFT_N(8), .BF_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .rd_addr_a(ra1), .rd_addr_b(rb1), .bf_enable(bf1),
    .tw_idx(tw1), .wr_en(wr1), .wr_addr_a(wa1), .wr_addr_b(wb1)
`ifdef FFT_BF_SCHED_CYCLE_CNT_EN
    , .cycle_count(cc1)
`endif
  );

  fft_bf_sched #(.FFT_N(8), .BF_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .busy(busy3), .done(done3),
    .rd_en(rd_en3), .rd_addr_a(ra3), .rd_addr_b(rb3), .bf_enable(bf3),
    .tw_idx(tw3), .wr_en(wr3), .wr_addr_a(wa3), .wr_addr_b(wb3)
`ifdef FFT_BF_SCHED_CYCLE_CNT_EN
    , .cycle_count(cc3)
`endif
  );

  always #5 clk = ~clk;

  snap_t s1w, s3w;
  assign s1w = {busy1, done1, rd_en1, ra1, rb1, bf1, tw1, wr1, wa1, wb1};
  assign s3w = {busy3, done3, rd_en3, ra3, rb3, bf3, tw3, wr3, wa3, wb3};

  int    cyc = 0;
  snap_t tr1 [TRMAX];
  snap_t tr3 [TRMAX];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (cyc < TRMAX) begin
      tr1[cyc] <= s1w;
      tr3[cyc] <= s3w;
    end
  end

  int total = 0;
  int bad   = 0;

  // Expected butterfly order per stage, derived group-by-group.
  int ea [LOG2N][N/2];
  int eb [LOG2N][N/2];
  int et [LOG2N][N/2];

  task automatic build_ref();
    for (int st = 0; st < LOG2N; st++) begin
      int span = 1 << st;
      int idx  = 0;
      for (int g = 0; g < N / (2 * span); g++) begin
        for (int p = 0; p < span; p++) begin
          ea[st][idx] = g * 2 * span + p;
          eb[st][idx] = g * 2 * span + p + span;
          et[st][idx] = p * (N / (2 * span));
          idx++;
        end
      end
    end
  endtask

  // Issue slot r (0-based offset from first busy cycle) -> stage/index.
  function automatic bit slot(input int lat, input int r, output int st, output int j);
    int p = N / 2 + 1 + lat;
    st = 0;
    j  = 0;
    if (r < 0) return 0;
    st = r / p;
    j  = r % p;
    return (st < LOG2N) && (j < N / 2);
  endfunction

  function automatic snap_t model(input int lat, input int rel, input int abort_rel);
    snap_t e;
    int    b, st, j;
    e = '0;
    b = LOG2N * (N / 2 + 1 + lat) + 1;
    if (rel < 1) return e;
    if (abort_rel > 0 && rel >= abort_rel) return e;
    e.busy = (rel <= b);
    e.done = (rel == b);
    if (slot(lat, rel - 1, st, j)) begin
      e.rd_en = 1'b1;
      e.ra = 3'(ea[st][j]);
      e.rb = 3'(eb[st][j]);
    end
    if (slot(lat, rel - 2, st, j)) begin
      e.bf = 1'b1;
      e.tw = 2'(et[st][j]);
    end
    if (slot(lat, rel - 2 - lat, st, j)) begin
      e.wr = 1'b1;
      e.wa = 3'(ea[st][j]);
      e.wb = 3'(eb[st][j]);
    end
    return e;
  endfunction

  task automatic chk_snap(input string name, input int c, input snap_t act, input snap_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One run: start at sc, optional extra start at sc+spur_rel, optional reset
  // during cycle sc+abort_rel. Returns sc after the whole window is checked.
  task automatic run_case(input int gap, input int spur_rel, input int abort_rel, output int sc);
    int nb1, nd1, nb3, nd3;
    repeat (gap) @(posedge clk);
    #1;
    start = 1'b1;
    sc = cyc;
    for (int r = 1; r <= WIN - 1; r++) begin
      @(posedge clk);
      #1;
      start = (r == spur_rel);
      reset = (r == abort_rel);
    end
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    nb1 = 0; nd1 = 0; nb3 = 0; nd3 = 0;
    for (int c = sc; c <= sc + WIN; c++) begin
      chk_snap("lat1_trace", c, tr1[c], model(1, c - sc, abort_rel));
      chk_snap("lat3_trace", c, tr3[c], model(3, c - sc, abort_rel));
      nb1 += int'(tr1[c].busy); nd1 += int'(tr1[c].done);
      nb3 += int'(tr3[c].busy); nd3 += int'(tr3[c].done);
    end
    if (abort_rel == 0) begin
      chk_int("lat1_busy_cycles", nb1, 19);
      chk_int("lat1_done_pulses", nd1, 1);
      chk_int("lat3_busy_cycles", nb3, 25);
      chk_int("lat3_done_pulses", nd3, 1);
`ifdef FFT_BF_SCHED_CYCLE_CNT_EN
      chk_int("lat1_cycle_count", int'(cc1), 19);
      chk_int("lat3_cycle_count", int'(cc3), 25);
`endif
    end
  endtask

  vec_t vecs [12];

  initial begin
    int sc, spur, abort_rel;
    snap_t z;

    vecs[0]  = '{0, 0, 3'd0, 3'd1, 2'd0};
    vecs[1]  = '{0, 1, 3'd2, 3'd3, 2'd0};
    vecs[2]  = '{0, 2, 3'd4, 3'd5, 2'd0};
    vecs[3]  = '{0, 3, 3'd6, 3'd7, 2'd0};
    vecs[4]  = '{1, 0, 3'd0, 3'd2, 2'd0};
    vecs[5]  = '{1, 1, 3'd1, 3'd3, 2'd2};
    vecs[6]  = '{1, 2, 3'd4, 3'd6, 2'd0};
    vecs[7]  = '{1, 3, 3'd5, 3'd7, 2'd2};
    vecs[8]  = '{2, 0, 3'd0, 3'd4, 2'd0};
    vecs[9]  = '{2, 1, 3'd1, 3'd5, 2'd1};
    vecs[10] = '{2, 2, 3'd2, 3'd6, 2'd2};
    vecs[11] = '{2, 3, 3'd3, 3'd7, 2'd3};

    build_ref();
    z = '0;
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_snap("reset_state_lat1", cyc, s1w, z);
    chk_snap("reset_state_lat3", cyc, s3w, z);
`ifdef FFT_BF_SCHED_CYCLE_CNT_EN
    chk_int("reset_cycle_count", int'(cc1), 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Clean run, then directed address table against the captured trace.
    run_case(2, 0, 0, sc);
    for (int i = 0; i < 12; i++) begin
      int    c1, c3;
      snap_t t;
      c1 = sc + 1 + vecs[i].st * 6 + vecs[i].j;
      c3 = sc + 1 + vecs[i].st * 8 + vecs[i].j;
      total++;
      t = tr1[c1];
      if (!(t.rd_en && t.ra == vecs[i].a && t.rb == vecs[i].b)) begin
        bad++;
        $display("FAIL vec%0d_read got=(%0d,%0d,en=%0b) expected=(%0d,%0d)", i, t.ra, t.rb, t.rd_en, vecs[i].a, vecs[i].b);
      end
      total++;
      t = tr1[c1 + 1];
      if (!(t.bf && t.tw == vecs[i].tw)) begin
        bad++;
        $display("FAIL vec%0d_twiddle got=(tw=%0d,bf=%0b) expected=%0d", i, t.tw, t.bf, vecs[i].tw);
      end
      total++;
      t = tr1[c1 + 2];
      if (!(t.wr && t.wa == vecs[i].a && t.wb == vecs[i].b)) begin
        bad++;
        $display("FAIL vec%0d_write_lat1 got=(%0d,%0d,en=%0b) expected=(%0d,%0d)", i, t.wa, t.wb, t.wr, vecs[i].a, vecs[i].b);
      end
      total++;
      t = tr3[c3 + 4];
      if (!(t.wr && t.wa == vecs[i].a && t.wb == vecs[i].b)) begin
        bad++;
        $display("FAIL vec%0d_write_lat3 got=(%0d,%0d,en=%0b) expected=(%0d,%0d)", i, t.wa, t.wb, t.wr, vecs[i].a, vecs[i].b);
      end
    end

    // start during stage-1 ISSUE, start in the DONE cycle, reset in stage-0 DRAIN,
    // then a full run after the abort.
    run_case(3, 8, 0, sc);
    run_case(2, 19, 0, sc);
    run_case(2, 0, 6, sc);
    run_case(3, 0, 0, sc);

    // Randomised runs: stray starts while busy and occasional mid-run resets.
    for (int i = 0; i < 10; i++) begin
      spur = int'($urandom_range(0, 19));
      abort_rel = ($urandom_range(0, 2) == 0) ? int'($urandom_range(spur + 1, 26)) : 0;
      run_case(int'($urandom_range(1, 4)), spur, abort_rel, sc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
